rr_mux_arbiter: RTL
===================

// Module: rr_mux_arbiter
// PURPOSE
//  Two-requester round-robin arbiter that owns a WIDTH-bit 2:1 data mux, sharing one output stream.
//  Each requester presents a valid/ready/last packet stream. A grant is locked for a whole packet.
//  Forward path is zero-latency once granted. Sits in front of any single-consumer sink.
// PARAMETERS
//  WIDTH    8   data width of each input and of the output
//  MAX_PKT  16  max beats per packet; the beat that reaches MAX_PKT without last forces a release
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst        in   1      synchronous, active-high reset
//  in0_valid  in   1      requester 0 beat valid
//  in0_data   in   WIDTH  requester 0 beat data
//  in0_last   in   1      requester 0 final beat of packet
//  in0_ready  out  1      requester 0 beat accepted when valid&ready
//  in1_valid  in   1      requester 1 beat valid
//  in1_data   in   WIDTH  requester 1 beat data
//  in1_last   in   1      requester 1 final beat of packet
//  in1_ready  out  1      requester 1 beat accepted when valid&ready
//  out_valid  out  1      output beat valid
//  out_data   out  WIDTH  muxed output data
//  out_last   out  1      muxed output last
//  out_ready  in   1      sink accepts beat
//  sel        out  1      current mux select (0=in0, 1=in1); registered
//  busy       out  1      1 while in GRANT0/GRANT1
//  pkt_err    out  1      1-cycle pulse on forced release (MAX_PKT beats, no last)
// BEHAVIOUR
//  - Clock and reset: one clock; reset is synchronous and active-high (ports clk, rst).
//  - Reset values: state=IDLE, sel=0, prio=0 (in0 wins first tie), beat_cnt=0, pkt_err=0.
//    Outputs follow: out_valid=0, in0_ready=0, in1_ready=0, busy=0.
//  - Reset mid-packet aborts the packet: no partial-packet replay, and the next grant follows prio=0.
//  - States:
//    - IDLE: no grant; all readies=0; out_valid=0.
//    - GRANT0 / GRANT1: requester sel is connected to the output.
//  - IDLE -> GRANTx:
//    - Only one valid: grant that one.
//    - Both valid: grant x=prio.
//    - sel<=x on the same edge.
//    - Arbitration costs exactly 1 cycle; the first beat can pass the cycle after valid is seen.
//  - In GRANTx (combinational, no latency):
//    - out_valid=inx_valid; out_data/out_last=inx_data/inx_last via mux.
//    - inx_ready=out_ready; the other ready=0.
//  - Beat accept = inx_valid & out_ready.
//    - Each accept: beat_cnt++.
//    - Release on an accept with inx_last=1, or with beat_cnt==MAX_PKT-1 (forced; pkt_err=1 next cycle).
//  - On release:
//    - prio<=~x, beat_cnt<=0.
//    - Other requester valid in the release cycle: go directly to GRANT(~x), no bubble, sel flips.
//    - Else only x valid: go to IDLE.
//    - Else: go to IDLE.
//    - No back-to-back self-grant; fairness is strict alternation when both are busy.
//  - Ungranted requester: valid may be held indefinitely; its ready stays 0; data must be held stable by the source.
//  - Granted requester dropping valid mid-packet: out_valid=0, grant held, no timeout.
//  - beat_cnt width: $clog2(MAX_PKT+1); never wraps (cleared at release).
//  - MAX_PKT=1: every beat releases; last is ignored for release, and pkt_err fires only if last=0.
// STRUCTURE
//  - Shared package rr_arb_pkg holds typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} arb_state_t.
//    It also holds the 1-bit select typedef.
//  - Sub-module mux2_w (WIDTH+1 bit 2:1 mux, data+last) selected by sel.
//  - Top holds the FSM, prio and beat_cnt.
// TESTING
//  1. Reset: assert rst 2 cycles with both valids high.
//     -> readies=0, out_valid=0, sel=0, busy=0; in0 granted first after release.
//  2. Single requester: in1 sends 3 beats (0xA1,0xA2,0xA3 last), out_ready=1.
//     -> IDLE 1 cycle, then GRANT1; out_data matches in order.
//     -> IDLE after the 3rd beat; prio=0.
//  3. Contention: both send 2-beat packets continuously.
//     -> output alternates in0,in1,in0 packets with no idle cycle between.
//     -> packets are never interleaved.
//  4. Backpressure: out_ready=0 for 4 cycles mid-packet.
//     -> granted ready=0, data held, beat_cnt unchanged, grant kept.
//     -> the other requester is not granted.
//  5. Runaway packet: MAX_PKT=16, in0 sends 20 beats with no last.
//     -> forced release after 16th accept; pkt_err pulses once.
//     -> in1 (valid) granted next cycle.
//  6. Reset mid-packet: rst after beat 2 of a 5-beat in1 packet.
//     -> next cycle IDLE, all readies 0.
//     -> after reset a tie grants in0.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types for the two-requester round-robin packet arbiter.
package rr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    // Mux select: 0 picks requester 0, 1 picks requester 1.
    typedef logic sel_t;

endpackage

// File: rtl/mux2_w.sv
// Plain W-bit 2:1 mux; the arbiter carries {last, data} through it.
module mux2_w
    import rr_arb_pkg::*;
#(
    parameter int W = 9
) (
    input  sel_t         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Two-requester round-robin packet arbiter driving a shared output stream.
// A grant is held for a whole packet; the data path is combinational once granted.
module rr_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_PKT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output sel_t             sel,
    output logic             busy,
    output logic             pkt_err,
    output arb_state_t       state_dbg
);

    // Handshake: a beat moves when valid & ready are both high on a rising edge.
    // valid must not wait on ready; the granted ready is simply out_ready.

    localparam int CW = $clog2(MAX_PKT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_PKT - 1);

    arb_state_t      state, state_next;
    sel_t            sel_next;
    logic            prio;
    logic [CW-1:0]   beat_cnt;

    logic            granted;
    logic            g1;
    logic            cur_valid;
    logic            cur_last;
    logic            other_valid;
    logic            accept;
    logic            forced;
    logic            release_pkt;
    logic [WIDTH:0]  mux_y;

    mux2_w #(.W(WIDTH + 1)) u_mux (
        .sel (sel),
        .a   ({in0_last, in0_data}),
        .b   ({in1_last, in1_data}),
        .y   (mux_y)
    );

    assign granted     = (state != IDLE);
    assign g1          = (state == GRANT1);
    assign cur_valid   = g1 ? in1_valid : in0_valid;
    assign cur_last    = g1 ? in1_last  : in0_last;
    assign other_valid = g1 ? in0_valid : in1_valid;

    assign accept      = granted & cur_valid & out_ready;
    assign forced      = (beat_cnt == CNT_LAST);
    assign release_pkt = accept & (cur_last | forced);

    assign out_valid = granted & cur_valid;
    assign out_data  = mux_y[WIDTH-1:0];
    assign out_last  = mux_y[WIDTH];
    assign in0_ready = (state == GRANT0) & out_ready;
    assign in1_ready = (state == GRANT1) & out_ready;
    assign busy      = granted;
    assign state_dbg = state;

    always_comb begin
        state_next = state;
        sel_next   = sel;
        case (state)
            IDLE: begin
                if (in0_valid && in1_valid) begin
                    state_next = prio ? GRANT1 : GRANT0;
                    sel_next   = prio;
                end else if (in0_valid) begin
                    state_next = GRANT0;
                    sel_next   = 1'b0;
                end else if (in1_valid) begin
                    state_next = GRANT1;
                    sel_next   = 1'b1;
                end
            end
            GRANT0: begin
                if (release_pkt) begin
                    if (other_valid) begin
                        state_next = GRANT1;
                        sel_next   = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            GRANT1: begin
                if (release_pkt) begin
                    if (other_valid) begin
                        state_next = GRANT0;
                        sel_next   = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                sel_next   = 1'b0;
            end
        endcase
    end

    // Reset discards any packet in flight; no replay state is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= 1'b0;
            prio     <= 1'b0;
            beat_cnt <= '0;
            pkt_err  <= 1'b0;
        end else begin
            state   <= state_next;
            sel     <= sel_next;
            pkt_err <= accept & forced & ~cur_last;
            if (release_pkt) begin
                prio     <= ~g1;
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

endmodule
